// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter and sequencing stage of the 9-bit RISC core.
// Owns the IDLE/RUN/HALT sequencer, the fetch address and a saturating
// run-cycle counter for the test harness.
//
// Optional feature macro: PC_OOB_EN
//   defined   : a taken branch whose full-precision target leaves
//               [0, 2^PC_W-1] halts the core with oob_err=1 and pc held.
//   undefined : branch targets wrap modulo 2^PC_W and oob_err is tied to 0.
//
// Ports:
//   clk        core clock, all state updates on posedge
//   reset      synchronous active-high reset
//   start      begin execution from START_ADDR (honoured in IDLE/HALT)
//   stall      freeze pc, state and counter for this RUN cycle
//   halt_req   decoded halt instruction at the current pc
//   branch_en  decoded taken branch at the current pc
//   bamt       signed 8-bit branch offset (register r1)
//   pc         current fetch address
//   running    high while in RUN
//   done       high while in HALT
//   cycle_cnt  non-stalled RUN cycles since the last start (saturating)
//   oob_err    branch-target-out-of-range flag
//
// PC_W must be at least 8 so that the full bamt range is representable.

module pc_ctrl #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_en,
  input  logic [7:0]       bamt,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             oob_err
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  pc_br;

  // Sequential successor, wraps naturally at 2^PC_W.
  assign pc_seq = pc + PC_W'(1);

  // Counter increment that sticks at all-ones instead of wrapping.
  assign cnt_inc = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);

`ifdef PC_OOB_EN
  localparam int unsigned TGT_W = PC_W + 2;

  logic [TGT_W-1:0] br_target;
  logic             br_oob;
  logic             oob_nxt;

  // Two guard bits hold the full-precision target: the top bit flags a
  // negative result, the next one a result above 2^PC_W-1.
  assign br_target = TGT_W'(pc) + TGT_W'($signed(bamt));
  assign br_oob    = br_target[TGT_W-1] | br_target[PC_W];
  assign pc_br     = br_target[PC_W-1:0];
`else
  // Sign-extend the offset to PC_W bits; the add wraps modulo 2^PC_W.
  assign pc_br = pc + PC_W'($signed(bamt));
`endif

  // Next-state, next-pc and counter decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cycle_cnt;
`ifdef PC_OOB_EN
    oob_nxt   = oob_err;
`endif

    case (state)
      S_IDLE: begin
        pc_nxt = START_PC;
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
`ifdef PC_OOB_EN
          oob_nxt   = 1'b0;
`endif
        end
      end

      S_RUN: begin
        // One action per cycle; stall beats halt beats branch beats step.
        if (stall) begin
          state_nxt = S_RUN;
        end else if (halt_req) begin
          state_nxt = S_HALT;
          cnt_nxt   = cnt_inc;
        end else if (branch_en) begin
          cnt_nxt = cnt_inc;
`ifdef PC_OOB_EN
          if (br_oob) begin
            state_nxt = S_HALT;
            oob_nxt   = 1'b1;
          end else begin
            pc_nxt = pc_br;
          end
`else
          pc_nxt = pc_br;
`endif
        end else begin
          pc_nxt  = pc_seq;
          cnt_nxt = cnt_inc;
        end
      end

      S_HALT: begin
        if (start) begin
          state_nxt = S_RUN;
          pc_nxt    = START_PC;
          cnt_nxt   = '0;
`ifdef PC_OOB_EN
          oob_nxt   = 1'b0;
`endif
        end
      end

      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = START_PC;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, pc, counter and status flags; running/done are registered
  // copies of the next-state decode so they track state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      cycle_cnt <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      cycle_cnt <= cnt_nxt;
      running   <= (state_nxt == S_RUN);
      done      <= (state_nxt == S_HALT);
    end
  end

`ifdef PC_OOB_EN
  // Sticky out-of-range flag, cleared only by reset or start.
  always_ff @(posedge clk) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else begin
      oob_err <= oob_nxt;
    end
  end
`else
  assign oob_err = 1'b0;
`endif

endmodule
